// File: rtl/mod_counter.sv
// WIDTH-bit up/down counter with runtime terminal value, wrap or saturate mode,
// registered carry/borrow-out and a saturating count of wrap events.
module mod_counter #(
    parameter int WIDTH      = 3,
    parameter bit SATURATE   = 1'b0,
    parameter int WRAP_CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  count_enable,
    input  logic                  up_down,
    input  logic [WIDTH-1:0]      limit,
    output logic [WIDTH-1:0]      count,
    output logic                  co,
    output logic                  at_term,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
);

    // Compared against the live limit, so a loaded value above limit is terminal in up mode.
    always_comb begin
        at_term = up_down ? (count >= limit) : (count == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            co       <= 1'b0;
            wrap_cnt <= '0;
        end else if (clr) begin
            count    <= '0;
            co       <= 1'b0;
            wrap_cnt <= '0;
        end else if (load) begin
            count <= load_val;
            co    <= 1'b0;
        end else if (count_enable) begin
            if (!at_term) begin
                count <= up_down ? count + 1'b1 : count - 1'b1;
                co    <= 1'b0;
            end else begin
                co <= 1'b1;
                if (!SATURATE) begin
                    count <= up_down ? '0 : limit;
                    if (wrap_cnt != '1) begin
                        wrap_cnt <= wrap_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Drives three mod_counter variants (wrap, saturate, 2-bit wrap count) from one
// stimulus stream and checks each against an arithmetic model every cycle.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n, clr, load, count_enable, up_down;
    logic [2:0] load_val, limit;

    logic [2:0] cnt_a [3];
    logic       co_a  [3];
    logic       at_a  [3];
    logic [3:0] wc_a  [3];
    logic [1:0] wc_small;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(3), .SATURATE(1'b0), .WRAP_CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .count_enable(count_enable), .up_down(up_down), .limit(limit),
        .count(cnt_a[0]), .co(co_a[0]), .at_term(at_a[0]), .wrap_cnt(wc_a[0]));

    mod_counter #(.WIDTH(3), .SATURATE(1'b1), .WRAP_CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .count_enable(count_enable), .up_down(up_down), .limit(limit),
        .count(cnt_a[1]), .co(co_a[1]), .at_term(at_a[1]), .wrap_cnt(wc_a[1]));

    mod_counter #(.WIDTH(3), .SATURATE(1'b0), .WRAP_CNT_W(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .count_enable(count_enable), .up_down(up_down), .limit(limit),
        .count(cnt_a[2]), .co(co_a[2]), .at_term(at_a[2]), .wrap_cnt(wc_small));

    assign wc_a[2] = {2'b00, wc_small};

    // Reference model: integer state per instance, stepped from the rules directly.
    int  mc [3];
    int  mco[3];
    int  mw [3];
    bit  msat[3] = '{1'b0, 1'b1, 1'b0};
    int  mwmax[3] = '{15, 15, 3};
    bit  mvalid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n || clr) begin
                mc[i] = 0; mco[i] = 0; mw[i] = 0;
            end else if (load) begin
                mc[i] = int'(load_val); mco[i] = 0;
            end else if (count_enable) begin
                bit term;
                term = up_down ? (mc[i] >= int'(limit)) : (mc[i] == 0);
                if (!term) begin
                    mc[i]  = up_down ? (mc[i] + 1) % 8 : mc[i] - 1;
                    mco[i] = 0;
                end else begin
                    mco[i] = 1;
                    if (!msat[i]) begin
                        mc[i] = up_down ? 0 : int'(limit);
                        if (mw[i] < mwmax[i]) mw[i] = mw[i] + 1;
                    end
                end
            end
        end
        if (!rst_n) mvalid = 1'b1;
    end

    task automatic cmp(input string nm, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t: got %0d expected %0d", nm, idx, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                int exp_at;
                exp_at = up_down ? int'(mc[i] >= int'(limit)) : int'(mc[i] == 0);
                cmp("count",   i, int'(cnt_a[i]), mc[i]);
                cmp("co",      i, int'(co_a[i]),  mco[i]);
                cmp("at_term", i, int'(at_a[i]),  exp_at);
                cmp("wrap",    i, int'(wc_a[i]),  mw[i]);
            end
        end
    end

    task automatic cyc(input logic r, input logic c, input logic l, input int lv,
                       input logic en, input logic ud, input int lim);
        rst_n = r; clr = c; load = l; load_val = 3'(lv);
        count_enable = en; up_down = ud; limit = 3'(lim);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        cmp({"lit_", nm}, 0, act, exp);
    endtask

    int exp_down[4] = '{1, 0, 5, 4};
    int exp_dco [4] = '{0, 0, 1, 0};
    int exp_sat [6] = '{1, 2, 3, 3, 3, 3};
    int exp_sco [6] = '{0, 0, 0, 1, 1, 1};

    initial begin
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        count_enable = 1'b0; up_down = 1'b1; limit = 3'd7;
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 0, 1, 7);
        lit("rst_count", int'(cnt_a[0]), 0);
        lit("rst_co",    int'(co_a[0]),  0);
        lit("rst_wrap",  int'(wc_a[0]),  0);

        // Up count to 7 then wrap, matching the legacy 3-bit counter
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 0, 0, 1, 1, 7);
            lit("up_count", int'(cnt_a[0]), i % 8);
            lit("up_co",    int'(co_a[0]),  (i == 8) ? 1 : 0);
        end
        lit("up_wrap", int'(wc_a[0]), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 1, 7);
            lit("hold_co", int'(co_a[0]), 1);
        end

        // Down with reload from limit
        cyc(0, 0, 0, 0, 0, 0, 5);
        cyc(1, 0, 1, 2, 0, 0, 5);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 1, 0, 5);
            lit("dn_count", int'(cnt_a[0]), exp_down[i]);
            lit("dn_co",    int'(co_a[0]),  exp_dco[i]);
        end
        lit("dn_wrap", int'(wc_a[0]), 1);

        // Load above limit is terminal; load beats enable
        cyc(1, 0, 1, 6, 0, 1, 4);
        lit("ld_count", int'(cnt_a[0]), 6);
        cyc(1, 0, 0, 0, 1, 1, 4);
        lit("ld_term_count", int'(cnt_a[0]), 0);
        lit("ld_term_co",    int'(co_a[0]),  1);
        lit("ld_term_wrap",  int'(wc_a[0]),  2);
        cyc(1, 0, 1, 3, 1, 1, 4);
        lit("ld_win_count", int'(cnt_a[0]), 3);
        lit("ld_win_co",    int'(co_a[0]),  0);

        // Saturating variant
        cyc(0, 0, 0, 0, 0, 1, 3);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0, 0, 1, 1, 3);
            lit("sat_count", int'(cnt_a[1]), exp_sat[i]);
            lit("sat_co",    int'(co_a[1]),  exp_sco[i]);
        end
        lit("sat_wrap", int'(wc_a[1]), 0);

        // Wrap counter saturation
        cyc(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1, 1, 1);
        lit("w2_wrap",  int'(wc_a[2]), 3);
        lit("w4_wrap",  int'(wc_a[0]), 10);
        lit("w2_count", int'(cnt_a[2]), 0);

        // Reset overrides load/enable mid-count; clr beats load
        cyc(1, 0, 0, 0, 1, 1, 7);
        cyc(1, 0, 0, 0, 1, 1, 7);
        cyc(0, 0, 1, 5, 1, 1, 7);
        lit("mid_rst_count", int'(cnt_a[0]), 0);
        lit("mid_rst_co",    int'(co_a[0]),  0);
        lit("mid_rst_wrap",  int'(wc_a[0]),  0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 1, 7);
        cyc(1, 0, 0, 0, 1, 1, 0);
        lit("lim_drop_count", int'(cnt_a[0]), 0);
        lit("lim_drop_co",    int'(co_a[0]),  1);
        cyc(1, 0, 0, 0, 1, 1, 0);
        lit("lim0_count", int'(cnt_a[0]), 0);
        lit("lim0_wrap",  int'(wc_a[0]),  2);
        cyc(1, 0, 0, 0, 1, 0, 6);
        lit("dn_reload", int'(cnt_a[0]), 6);
        cyc(1, 0, 0, 0, 1, 1, 7);
        cyc(1, 0, 0, 0, 1, 0, 7);
        cyc(1, 0, 0, 0, 1, 1, 5);
        cyc(1, 1, 1, 5, 1, 1, 7);
        lit("clr_count", int'(cnt_a[0]), 0);
        lit("clr_wrap",  int'(wc_a[0]),  0);
        cyc(1, 0, 0, 0, 0, 1, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
